// File: rtl/dma_pkg.sv
// dma_pkg: shared types and helpers for the DMA transfer controller.
//   state_e        - controller FSM states
//   bytes_per_word - byte stride of one bus word of a given bit width
//   BYTES_PER_WORD - stride for the default 32-bit data path
//   min_u          - unsigned minimum, used to size each burst
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_BUF_RD,
    S_BUF_WAIT,
    S_WR_REQ,
    S_DONE
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(32);

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: copies i_len words from a source region to a destination
// region, staging up to DEPTH words at a time in an external word buffer.
//   clk, rst            - clock, asynchronous active-low reset
//   i_start, i_src_addr, i_dst_addr, i_len - transfer request (latched in IDLE)
//   o_busy, o_done      - transfer in progress / one-cycle completion pulse
//   o_m_*, i_m_*        - master bus: one request at a time, held until ready
//   o_buf_*, i_buf_*    - word buffer: write strobe, or read strobe with
//                         data returned one cycle later
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_m_valid,
  output logic                  o_m_rd0_wr1,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic [DATA_WIDTH-1:0] o_m_wdata,
  input  logic                  i_m_ready,
  input  logic [DATA_WIDTH-1:0] i_m_rdata,
  input  logic                  i_m_rvalid,
  output logic                  o_buf_rd0_wr1,
  output logic                  o_buf_valid,
  output logic [DATA_WIDTH-1:0] o_buf_data,
  input  logic [DATA_WIDTH-1:0] i_buf_data,
  input  logic                  i_buf_valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(bytes_per_word(DATA_WIDTH));

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      burst_q, burst_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LEN_WIDTH-1:0]  rem_dec;
  logic                  last_in_burst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    burst_d       = burst_q;
    wdata_d       = wdata_q;
    rem_dec       = rem_q - LEN_WIDTH'(1);
    last_in_burst = (cnt_q == burst_q - CNT_W'(1));

    o_busy        = (state_q != S_IDLE);
    o_done        = 1'b0;
    o_m_valid     = 1'b0;
    o_m_rd0_wr1   = 1'b0;
    o_m_addr      = '0;
    o_m_wdata     = '0;
    o_buf_rd0_wr1 = 1'b0;
    o_buf_valid   = 1'b0;
    o_buf_data    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          src_d   = i_src_addr;
          dst_d   = i_dst_addr;
          rem_d   = i_len;
          burst_d = CNT_W'(min_u(32'(i_len), DEPTH));
          cnt_d   = '0;
          state_d = (i_len == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        o_m_valid = 1'b1;
        o_m_addr  = src_q;
        if (i_m_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Read data is forwarded straight into the buffer in its arrival cycle.
        if (i_m_rvalid) begin
          o_buf_valid   = 1'b1;
          o_buf_rd0_wr1 = 1'b1;
          o_buf_data    = i_m_rdata;
          src_d         = src_q + ADDR_STEP;
          if (last_in_burst) begin
            cnt_d   = '0;
            state_d = S_BUF_RD;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_RD_REQ;
          end
        end
      end
      S_BUF_RD: begin
        o_buf_valid = 1'b1;
        state_d     = S_BUF_WAIT;
      end
      S_BUF_WAIT: begin
        if (i_buf_valid) begin
          wdata_d = i_buf_data;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        o_m_valid   = 1'b1;
        o_m_rd0_wr1 = 1'b1;
        o_m_addr    = dst_q;
        o_m_wdata   = wdata_q;
        if (i_m_ready) begin
          dst_d = dst_q + ADDR_STEP;
          rem_d = rem_dec;
          if (!last_in_burst) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_BUF_RD;
          end else if (rem_dec == '0) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            burst_d = CNT_W'(min_u(32'(rem_dec), DEPTH));
            cnt_d   = '0;
            state_d = S_RD_REQ;
          end
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// tb_dma_xfer_ctrl: bench for dma_xfer_ctrl. A bus/buffer responder answers
// the DUT with configurable stalls and read latency; every accepted bus
// request is logged and compared against the transfer sequence computed from
// the burst rules (reads of a burst, then writes of the same words).
module tb_dma_xfer_ctrl;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_src_addr, i_dst_addr;
  logic [15:0] i_len;
  logic        o_busy, o_done, o_m_valid, o_m_rd0_wr1;
  logic [31:0] o_m_addr, o_m_wdata;
  logic        i_m_ready;
  logic [31:0] i_m_rdata;
  logic        i_m_rvalid;
  logic        o_buf_rd0_wr1, o_buf_valid;
  logic [31:0] o_buf_data, i_buf_data;
  logic        i_buf_valid;

  dma_xfer_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_src_addr(i_src_addr),
    .i_dst_addr(i_dst_addr), .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
    .o_m_valid(o_m_valid), .o_m_rd0_wr1(o_m_rd0_wr1), .o_m_addr(o_m_addr),
    .o_m_wdata(o_m_wdata), .i_m_ready(i_m_ready), .i_m_rdata(i_m_rdata),
    .i_m_rvalid(i_m_rvalid), .o_buf_rd0_wr1(o_buf_rd0_wr1), .o_buf_valid(o_buf_valid),
    .o_buf_data(o_buf_data), .i_buf_data(i_buf_data), .i_buf_valid(i_buf_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int unsigned len;
    int unsigned smin;
    int unsigned smax;
    int unsigned rvd;
    int unsigned dmode;
    int unsigned exp_busy; // 0: latency not checked
    bit          poke;     // pulse i_start while busy and on o_done
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // responder configuration and observation state
  int unsigned smin = 0, smax = 0, rvd = 1, dmode = 0, stall_left = 0;
  logic [31:0] seed = 32'h1234_5678;
  ev_t         obs[$];
  logic [31:0] fifo[$];
  int unsigned busy_cnt = 0, done_cnt = 0, buf_acts = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] a);
    case (dmode)
      0:       return 32'hAAAA_AAAA;
      1:       return a >> 2;
      default: return (a * 32'h9E37_79B1) ^ seed;
    endcase
  endfunction

  // Bus and buffer responder: drives inputs just after each falling edge,
  // then samples the settled outputs 1 ns later.
  initial begin : responder
    bit          rd_pend = 0, buf_rd_pend = 0, prev_stall = 0;
    int unsigned rd_cnt = 0;
    logic [31:0] rd_addr = '0;
    ev_t         prev;
    prev = '{0, '0, '0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        rd_pend = 0; buf_rd_pend = 0; prev_stall = 0;
        fifo.delete();
        i_m_ready = 0; i_m_rvalid = 0; i_m_rdata = '0;
        i_buf_valid = 0; i_buf_data = '0;
        continue;
      end
      i_m_rvalid = 0;
      i_m_rdata  = $urandom;
      if (rd_pend) begin
        if (rd_cnt <= 1) begin
          i_m_rvalid = 1;
          i_m_rdata  = src_word(rd_addr);
          rd_pend    = 0;
        end else rd_cnt--;
      end
      i_buf_valid = 0;
      i_buf_data  = $urandom;
      if (buf_rd_pend) begin
        buf_rd_pend = 0;
        i_buf_valid = 1;
        chk("buf_underflow", 64'(fifo.size() != 0), 64'd1);
        if (fifo.size() != 0) i_buf_data = fifo.pop_front();
      end
      if (o_m_valid) begin
        if (stall_left > 0) begin
          i_m_ready = 0;
          stall_left--;
        end else i_m_ready = 1;
      end else i_m_ready = 1'($urandom_range(1, 0));

      #1;
      if (o_busy) busy_cnt++;
      if (o_done) done_cnt++;
      if (o_m_valid) begin
        if (prev_stall) begin
          chk("stall_addr", 64'(o_m_addr), 64'(prev.addr));
          chk("stall_type", 64'(o_m_rd0_wr1), 64'(prev.wr));
          if (prev.wr) chk("stall_wdata", 64'(o_m_wdata), 64'(prev.data));
        end
        if (i_m_ready) begin
          obs.push_back('{o_m_rd0_wr1, o_m_addr, o_m_rd0_wr1 ? o_m_wdata : 32'h0});
          if (!o_m_rd0_wr1) begin
            rd_pend = 1; rd_cnt = rvd; rd_addr = o_m_addr;
          end
          stall_left = $urandom_range(smax, smin);
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev = '{o_m_rd0_wr1, o_m_addr, o_m_wdata};
        end
      end else if (prev_stall) begin
        chk("valid_dropped", 64'd0, 64'd1);
        prev_stall = 0;
      end
      if (o_buf_valid) begin
        buf_acts++;
        if (o_buf_rd0_wr1) begin
          fifo.push_back(o_buf_data);
          chk("buf_overflow", 64'(fifo.size() <= DEPTH), 64'd1);
        end else buf_rd_pend = 1;
      end
    end
  end

  task automatic run_xfer(input vec_t v, input string tag);
    ev_t         exp_q[$];
    int unsigned rem, b, n, nmin;
    logic [31:0] s, d;
    bit          timed_out;
    smin = v.smin; smax = v.smax; rvd = v.rvd; dmode = v.dmode;
    rem = v.len; s = v.src; d = v.dst;
    while (rem > 0) begin
      b = (rem < DEPTH) ? rem : DEPTH;
      for (int unsigned i = 0; i < b; i++) exp_q.push_back('{1'b0, s + 4 * i, 32'h0});
      for (int unsigned i = 0; i < b; i++) exp_q.push_back('{1'b1, d + 4 * i, src_word(s + 4 * i)});
      s += 4 * b; d += 4 * b; rem -= b;
    end

    @(negedge clk); #2;
    obs.delete(); busy_cnt = 0; done_cnt = 0; buf_acts = 0;
    stall_left = $urandom_range(smax, smin);
    i_start = 1; i_src_addr = v.src; i_dst_addr = v.dst; i_len = 16'(v.len);
    n = 0; timed_out = 0;
    while (1) begin
      @(negedge clk); #2;
      i_start = 0; i_src_addr = $urandom; i_dst_addr = $urandom; i_len = 16'($urandom);
      n++;
      if (v.poke && n == 3) begin
        i_start = 1; i_len = 16'd7;
      end
      if (o_done) break;
      if (n > 20000) begin
        timed_out = 1;
        break;
      end
    end
    chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
    if (v.poke && !timed_out) begin
      i_start = 1; i_len = 16'd5;
    end
    @(negedge clk); #2;
    i_start = 0;
    repeat (3) begin
      @(negedge clk); #2;
    end
    chk({tag, "_idle_after"}, 64'(o_busy), 64'd0);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
    if (v.exp_busy != 0) chk({tag, "_latency"}, 64'(n), 64'(v.exp_busy));
    chk({tag, "_buf_accesses"}, 64'(buf_acts), 64'(2 * v.len));
    chk({tag, "_req_count"}, 64'(obs.size()), 64'(exp_q.size()));
    nmin = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int unsigned i = 0; i < nmin; i++) begin
      chk({tag, "_req_addr"}, 64'(obs[i].addr), 64'(exp_q[i].addr));
      chk({tag, "_req_type_data"}, {31'h0, obs[i].wr, obs[i].data}, {31'h0, exp_q[i].wr, exp_q[i].data});
    end
  endtask

  vec_t vecs[$];

  initial begin : main
    int unsigned w;
    rst = 0; i_start = 0; i_src_addr = '0; i_dst_addr = '0; i_len = '0;
    i_m_ready = 0; i_m_rdata = '0; i_m_rvalid = 0; i_buf_data = '0; i_buf_valid = 0;

    //           src           dst           len smin smax rvd mode busy poke
    vecs.push_back('{32'h0000_1000, 32'h0000_2000,  1, 0, 0, 1, 0,   6, 0});
    vecs.push_back('{32'h0000_1000, 32'h0000_2000, 20, 0, 0, 1, 1, 101, 0});
    vecs.push_back('{32'h0000_1000, 32'h0000_2000,  0, 0, 0, 1, 1,   1, 0});
    vecs.push_back('{32'h0000_3000, 32'h0000_4000,  3, 5, 5, 3, 2,   0, 0});
    vecs.push_back('{32'hFFFF_FFF8, 32'hFFFF_FFFC,  5, 0, 2, 2, 2,   0, 0});
    vecs.push_back('{32'h0000_0100, 32'h0000_0200, 16, 0, 0, 1, 2,  81, 0});
    vecs.push_back('{32'h0000_0007, 32'h0000_2003, 17, 0, 3, 1, 2,   0, 1});
    vecs.push_back('{32'h0000_5000, 32'h0000_6000,  0, 0, 0, 1, 2,   1, 1});

    #23;
    chk("reset_outputs", 64'({o_busy, o_done, o_m_valid, o_m_rd0_wr1, o_buf_rd0_wr1, o_buf_valid}), 64'd0);
    chk("reset_buses", 64'(o_m_addr | o_m_wdata | o_buf_data), 64'd0);
    @(negedge clk); #2; rst = 1;

    foreach (vecs[k]) run_xfer(vecs[k], $sformatf("vec%0d", k));

    for (int r = 0; r < 8; r++) begin
      vec_t v;
      v = '{$urandom, $urandom, $urandom_range(40, 0), 0, $urandom_range(3, 0),
            $urandom_range(4, 1), 2, 0, 1'($urandom_range(1, 0))};
      run_xfer(v, $sformatf("rand%0d", r));
    end

    // Reset while waiting for read data: read latency long enough to park in RD_WAIT.
    rvd = 6; smin = 0; smax = 0; dmode = 2;
    @(negedge clk); #2;
    obs.delete(); done_cnt = 0; stall_left = 0;
    i_start = 1; i_src_addr = 32'h0000_8000; i_dst_addr = 32'h0000_9000; i_len = 16'd4;
    @(negedge clk); #2;
    i_start = 0;
    w = 0;
    while (obs.size() == 0 && w < 50) begin
      @(negedge clk); #2;
      w++;
    end
    chk("rstmid_read_seen", 64'(obs.size()), 64'd1);
    @(posedge clk); #3;
    rst = 0;
    #1;
    chk("rstmid_outputs", 64'({o_busy, o_done, o_m_valid, o_m_rd0_wr1, o_buf_rd0_wr1, o_buf_valid}), 64'd0);
    chk("rstmid_buses", 64'(o_m_addr | o_m_wdata | o_buf_data), 64'd0);
    repeat (3) @(negedge clk);
    #2;
    chk("rstmid_no_done", 64'(done_cnt), 64'd0);
    chk("rstmid_busy", 64'(o_busy), 64'd0);
    rst = 1;

    // Recovery after the aborted transfer.
    run_xfer('{32'h0000_1000, 32'h0000_2000, 2, 0, 0, 1, 1, 11, 0}, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
